// File: rtl/machine_mode_types_1_12_pkg.sv
// Shared types for the machine-mode interrupt controller.
//   int_ctrl_state_t : request/service state of the trap handshake.
//   PRIO_W_DEFAULT   : default width of a per-source priority field.
package machine_mode_types_1_12_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } int_ctrl_state_t;

    localparam int unsigned PRIO_W_DEFAULT = 3;

endpackage

// File: rtl/priv_1_12_int_prio_arb.sv
// Combinational priority arbiter for the interrupt controller.
//   cand     : candidate vector (pending, enabled sources)
//   prio     : packed priorities, source i at [i*PRIO_W +: PRIO_W]
//   any_cand : at least one candidate with non-zero priority
//   winner   : index of the highest-priority candidate, lowest index on ties
module priv_1_12_int_prio_arb #(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned PRIO_W  = 3,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0]        cand,
    input  logic [NUM_SRC*PRIO_W-1:0] prio,
    output logic                      any_cand,
    output logic [ID_W-1:0]           winner
);

    logic [PRIO_W-1:0] best;

    // Strictly-greater compare keeps the earliest index on equal priority,
    // and starting from zero drops priority-0 (masked) sources for free.
    always_comb begin
        best     = '0;
        winner   = '0;
        any_cand = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (cand[i] && (prio[i*PRIO_W +: PRIO_W] > best)) begin
                best     = prio[i*PRIO_W +: PRIO_W];
                winner   = ID_W'(i);
                any_cand = 1'b1;
            end
        end
    end

endmodule

// File: rtl/priv_1_12_int_ctrl.sv
// N-source machine-level interrupt controller.
// Latches per-source pending bits (edge or level), arbitrates by programmable
// priority, and runs a registered request/ack handshake to pipe control with
// in-service tracking released by mret.
// Ports:
//   CLK, nRST    : clock, asynchronous active-low reset
//   src_irq      : raw interrupt lines
//   src_edge     : per-source mode, 1 = rising edge, 0 = level
//   src_en       : per-source enables (mie)
//   src_prio     : packed priorities, 0 = masked
//   global_ie    : mstatus.mie
//   clear_pend   : software clear of edge-pending bits
//   trap_ack     : pipe has taken the requested trap
//   complete     : mret retired
//   pending      : pending vector (mip)
//   trap_req     : trap request to pipe control
//   trap_id      : winning source index
//   in_service   : trap being serviced
// Optional: define PRIV_INT_CTRL_SYNC_EN to add a 2-flop synchroniser on each
// src_irq bit (irq-to-trap_req latency 4 cycles instead of 2).
module priv_1_12_int_ctrl
    import machine_mode_types_1_12_pkg::*;
#(
    parameter int unsigned NUM_SRC = 16,
    parameter int unsigned PRIO_W  = PRIO_W_DEFAULT,
    parameter int unsigned ID_W    = $clog2(NUM_SRC)
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic [NUM_SRC-1:0]        src_irq,
    input  logic [NUM_SRC-1:0]        src_edge,
    input  logic [NUM_SRC-1:0]        src_en,
    input  logic [NUM_SRC*PRIO_W-1:0] src_prio,
    input  logic                      global_ie,
    input  logic [NUM_SRC-1:0]        clear_pend,
    input  logic                      trap_ack,
    input  logic                      complete,
    output logic [NUM_SRC-1:0]        pending,
    output logic                      trap_req,
    output logic [ID_W-1:0]           trap_id,
    output logic                      in_service
);

    int_ctrl_state_t    state;
    logic [NUM_SRC-1:0] irq_s;
    logic [NUM_SRC-1:0] prev;
    logic [NUM_SRC-1:0] ack_clr;
    logic [NUM_SRC-1:0] pend_nxt;
    logic [NUM_SRC-1:0] prio_nz;
    logic [NUM_SRC-1:0] cand;
    logic               any_cand;
    logic [ID_W-1:0]    winner;
    logic               ack_go;

`ifdef PRIV_INT_CTRL_SYNC_EN
    logic [NUM_SRC-1:0] sync_q1;
    logic [NUM_SRC-1:0] sync_q2;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= src_irq;
            sync_q2 <= sync_q1;
        end
    end

    assign irq_s = sync_q2;
`else
    assign irq_s = src_irq;
`endif

    // An ack only clears the pending bit of the source being requested.
    assign ack_go = (state == REQ) && trap_ack;

    always_comb begin
        ack_clr = '0;
        prio_nz = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            ack_clr[i] = ack_go && (trap_id == ID_W'(i));
            prio_nz[i] = |src_prio[i*PRIO_W +: PRIO_W];
        end
    end

    // Edge bits: set has priority over clear. Level bits follow the input.
    assign pend_nxt = (src_edge & (((pending & ~(clear_pend | ack_clr))) | (irq_s & ~prev)))
                    | (~src_edge & irq_s);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            prev    <= '0;
            pending <= '0;
        end else begin
            prev    <= irq_s;
            pending <= pend_nxt;
        end
    end

    assign cand = pending & src_en & prio_nz;

    priv_1_12_int_prio_arb #(
        .NUM_SRC (NUM_SRC),
        .PRIO_W  (PRIO_W),
        .ID_W    (ID_W)
    ) u_arb (
        .cand     (cand),
        .prio     (src_prio),
        .any_cand (any_cand),
        .winner   (winner)
    );

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            trap_req   <= 1'b0;
            trap_id    <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (global_ie && any_cand) begin
                        state    <= REQ;
                        trap_req <= 1'b1;
                        trap_id  <= winner;
                    end
                end
                REQ: begin
                    // Ack outranks withdrawal; trap_id is frozen while requesting.
                    if (trap_ack) begin
                        state      <= SERVICE;
                        trap_req   <= 1'b0;
                        in_service <= 1'b1;
                    end else if (!(global_ie && cand[trap_id])) begin
                        state    <= IDLE;
                        trap_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (complete) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    trap_req   <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_priv_1_12_int_ctrl.sv
// Self-checking bench for priv_1_12_int_ctrl: directed scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
module tb_priv_1_12_int_ctrl;

    localparam int NS = 16;
    localparam int PW = 3;
    localparam int IW = 4;
`ifdef PRIV_INT_CTRL_SYNC_EN
    localparam int LAT  = 4;
    localparam bit SYNC = 1'b1;
`else
    localparam int LAT  = 2;
    localparam bit SYNC = 1'b0;
`endif

    logic            CLK = 1'b0;
    logic            nRST;
    logic [NS-1:0]   src_irq, src_edge, src_en, clear_pend;
    logic [NS*PW-1:0] src_prio;
    logic            global_ie, trap_ack, complete;
    logic [NS-1:0]   pending;
    logic            trap_req, in_service;
    logic [IW-1:0]   trap_id;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_pend [NS];
    bit m_prev [NS];
    bit m_s1   [NS];
    bit m_s2   [NS];
    int m_mode;   // 0 idle, 1 requesting, 2 in service
    int m_id;

    always #5 CLK = ~CLK;

    priv_1_12_int_ctrl #(
        .NUM_SRC (NS),
        .PRIO_W  (PW),
        .ID_W    (IW)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .src_irq    (src_irq),
        .src_edge   (src_edge),
        .src_en     (src_en),
        .src_prio   (src_prio),
        .global_ie  (global_ie),
        .clear_pend (clear_pend),
        .trap_ack   (trap_ack),
        .complete   (complete),
        .pending    (pending),
        .trap_req   (trap_req),
        .trap_id    (trap_id),
        .in_service (in_service)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int prio_of(input int i);
        return int'(src_prio[i*PW +: PW]);
    endfunction

    task automatic set_prio(input int i, input int p);
        src_prio[i*PW +: PW] = PW'(p);
    endtask

    function automatic bit is_cand(input int i);
        return m_pend[i] && src_en[i] && (prio_of(i) != 0);
    endfunction

    // Scan priority levels from the top; first index found at a level wins.
    function automatic int best_src();
        for (int p = (1 << PW) - 1; p >= 1; p--)
            for (int i = 0; i < NS; i++)
                if (is_cand(i) && prio_of(i) == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = 0; m_prev[i] = 0; m_s1[i] = 0; m_s2[i] = 0;
        end
        m_mode = 0;
        m_id   = 0;
    endtask

    task automatic model_clock();
        bit eff [NS];
        bit np  [NS];
        int b;
        bit id_ok;
        b     = best_src();
        id_ok = (m_mode == 1) && is_cand(m_id);
        for (int i = 0; i < NS; i++) begin
            eff[i] = SYNC ? m_s2[i] : src_irq[i];
            if (src_edge[i]) begin
                if (eff[i] && !m_prev[i]) np[i] = 1;
                else if (clear_pend[i] || (m_mode == 1 && trap_ack && m_id == i)) np[i] = 0;
                else np[i] = m_pend[i];
            end else begin
                np[i] = eff[i];
            end
        end
        case (m_mode)
            0: if (global_ie && b >= 0) begin m_mode = 1; m_id = b; end
            1: if (trap_ack) m_mode = 2;
               else if (!(global_ie && id_ok)) m_mode = 0;
            default: if (complete) m_mode = 0;
        endcase
        for (int i = 0; i < NS; i++) begin
            m_pend[i] = np[i];
            m_prev[i] = eff[i];
            m_s2[i]   = m_s1[i];
            m_s1[i]   = src_irq[i];
        end
    endtask

    task automatic step();
        logic [NS-1:0] exp_p;
        @(posedge CLK);
        model_clock();
        #1;
        for (int i = 0; i < NS; i++) exp_p[i] = m_pend[i];
        check("pend", pending, exp_p);
        check("req", trap_req, (m_mode == 1));
        check("svc", in_service, (m_mode == 2));
        if (m_mode == 1) check("id", trap_id, m_id);
    endtask

    task automatic init_inputs();
        src_irq    = '0;
        src_edge   = '0;
        src_en     = '1;
        src_prio   = '0;
        global_ie  = 1'b1;
        clear_pend = '0;
        trap_ack   = 1'b0;
        complete   = 1'b0;
    endtask

    // Asynchronous reset pulse between clock edges.
    task automatic do_reset();
        #2 nRST = 1'b0;
        #1;
        check("rst_req", trap_req, 0);
        check("rst_svc", in_service, 0);
        check("rst_id", trap_id, 0);
        check("rst_pend", pending, 0);
        model_reset();
        #1 nRST = 1'b1;
    endtask

    initial begin
        nRST = 1'b0;
        init_inputs();
        model_reset();
        #3;
        check("por_req", trap_req, 0);
        check("por_svc", in_service, 0);
        check("por_pend", pending, 0);
        check("por_id", trap_id, 0);
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;

        // Edge source 3, single pulse: exact latency and ack/complete.
        src_edge[3] = 1'b1;
        set_prio(3, 2);
        src_irq[3] = 1'b1;
        step();
        src_irq[3] = 1'b0;
        for (int n = 1; n < LAT - 1; n++) step();
        check("e_pend", pending[3], 1);
        check("e_req_early", trap_req, 0);
        step();
        check("e_req", trap_req, 1);
        check("e_id", trap_id, 3);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("e_ack_pend", pending[3], 0);
        check("e_ack_svc", in_service, 1);
        repeat (3) step();
        check("e_hold_svc", in_service, 1);
        complete = 1'b1;
        step();
        complete = 1'b0;
        check("e_done_svc", in_service, 0);
        step();
        check("e_done_req", trap_req, 0);

        // Priority and tie break on level sources.
        init_inputs();
        do_reset();
        set_prio(2, 5); set_prio(7, 5); set_prio(9, 6);
        src_irq[2] = 1'b1; src_irq[7] = 1'b1; src_irq[9] = 1'b1;
        repeat (LAT) step();
        check("p_req", trap_req, 1);
        check("p_id9", trap_id, 9);
        src_irq[9] = 1'b0;
        trap_ack   = 1'b1;
        step();
        trap_ack = 1'b0;
        check("p_svc", in_service, 1);
        repeat (LAT) step();
        complete = 1'b1;
        step();
        complete = 1'b0;
        step();
        check("p_req2", trap_req, 1);
        check("p_id2", trap_id, 2);

        // Withdrawal when the level source drops before ack.
        init_inputs();
        do_reset();
        set_prio(4, 1);
        src_irq[4] = 1'b1;
        repeat (LAT) step();
        check("w_req", trap_req, 1);
        check("w_id", trap_id, 4);
        src_irq[4] = 1'b0;
        repeat (LAT - 1) step();
        check("w_pend", pending[4], 0);
        check("w_req_hold", trap_req, 1);
        step();
        check("w_req_drop", trap_req, 0);
        check("w_svc", in_service, 0);

        // Masking by priority 0, src_en and global_ie.
        init_inputs();
        do_reset();
        src_edge[5] = 1'b1;
        src_irq[5]  = 1'b1;
        step();
        src_irq[5] = 1'b0;
        repeat (LAT) step();
        for (int n = 0; n < 60; n++) begin
            if (n == 20) begin set_prio(5, 3); src_en[5] = 1'b0; end
            if (n == 40) begin src_en[5] = 1'b1; global_ie = 1'b0; end
            step();
            check("m_req", trap_req, 0);
            check("m_pend", pending[5], 1);
        end
        global_ie = 1'b1;
        step();
        check("m_unmask_req", trap_req, 1);
        check("m_unmask_id", trap_id, 5);

        // Set and clear of an edge pending bit in the same cycle.
        init_inputs();
        do_reset();
        src_edge[1] = 1'b1;
        set_prio(1, 1);
        src_irq[1] = 1'b1;
        repeat (LAT - 2) step();
        clear_pend[1] = 1'b1;
        step();
        clear_pend[1] = 1'b0;
        check("sc_pend", pending[1], 1);

        // Ack coinciding with a level drop of the requested source.
        init_inputs();
        do_reset();
        set_prio(6, 2);
        src_irq[6] = 1'b1;
        repeat (LAT) step();
        src_irq[6] = 1'b0;
        repeat (LAT - 1) step();
        check("al_req", trap_req, 1);
        check("al_pend", pending[6], 0);
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("al_svc", in_service, 1);
        check("al_req_off", trap_req, 0);

        // Reset during REQ and during SERVICE.
        init_inputs();
        do_reset();
        set_prio(8, 4);
        src_irq[8] = 1'b1;
        repeat (LAT) step();
        check("r1_req", trap_req, 1);
        src_irq = '0;
        do_reset();
        repeat (5) begin step(); check("r1_stale", trap_req, 0); end
        src_irq[8] = 1'b1;
        repeat (LAT) step();
        trap_ack = 1'b1;
        step();
        trap_ack = 1'b0;
        check("r2_svc", in_service, 1);
        src_irq = '0;
        do_reset();
        repeat (5) begin
            step();
            check("r2_stale_req", trap_req, 0);
            check("r2_stale_svc", in_service, 0);
        end
        src_irq[8] = 1'b1;
        repeat (LAT) step();
        check("r2_new_req", trap_req, 1);

        // Randomized traffic against the model.
        init_inputs();
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 64 == 0) begin
                src_edge  = NS'($urandom);
                src_en    = NS'($urandom | $urandom);
                src_prio  = {$urandom, $urandom};
                global_ie = ($urandom_range(0, 7) != 0);
            end
            src_irq    = src_irq ^ NS'($urandom & $urandom & $urandom);
            clear_pend = NS'($urandom & $urandom & $urandom & $urandom);
            trap_ack   = ($urandom_range(0, 3) == 0);
            complete   = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 299) == 0) do_reset();
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
